adc_sar_sequencer: RTL and testbench

- Multi-channel scan controller for the adc_sar digital core.
- Steps an analog input mux over the enabled channels and waits a programmable settle time after each switch.
- Launches each conversion through the soc/eoc handshake and captures dout on eoc_it.
- Publishes tagged results; sits between the register bank and adc_sar.

---
 rtl/adc_sar_pkg.sv | 43 ++++
 rtl/adc_sar_sequencer_if.sv | 28 ++
 rtl/adc_sar_seq_chpick.sv | 43 ++++
 rtl/adc_sar_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_adc_sar_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sar_pkg.sv
// Shared types and helpers for the adc_sar scan sequencer.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package adc_sar_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SOC    = 3'd2,
        CONV   = 3'd3,
        NEXT   = 3'd4
    } seq_state_t;

    // Extra accumulator headroom so up to 8 full-scale samples can be summed.
    localparam int ADC_SEQ_ACC_EXTRA = 3;

    // Returns {wrap, idx}: idx is the lowest set bit strictly above cur.
    // When no such bit exists, wrap=1 and idx is the lowest set bit overall.
    // Calling with cur=15 therefore always yields the lowest set bit.
    function automatic logic [4:0] next_channel(input logic [15:0] mask,
                                                input logic [3:0]  cur);
        logic       found;
        logic       low_found;
        logic [3:0] idx;
        logic [3:0] low;
        found     = 1'b0;
        low_found = 1'b0;
        idx       = 4'd0;
        low       = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i] && !low_found) begin
                low       = 4'(i);
                low_found = 1'b1;
            end
            if (mask[i] && !found && (i > int'(cur))) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return found ? {1'b0, idx} : {1'b1, low};
    endfunction

endpackage

// File: rtl/adc_sar_sequencer_if.sv
// ADC-side handshake and tagged-result bus of the scan sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; res_valid is a strobe, the adc side paces via adc_eoc.
interface adc_sar_sequencer_if #(
    parameter int N   = 12,
    parameter int NCH = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0] ch_sel;
    logic          adc_soc;
    logic          adc_eoc;
    logic          adc_eoc_it;
    logic [N-1:0]  adc_dout;
    logic          res_valid;
    logic [CW-1:0] res_ch;
    logic [N-1:0]  res_data;

    modport master (
        output ch_sel, adc_soc, res_valid, res_ch, res_data,
        input  adc_eoc, adc_eoc_it, adc_dout
    );

    modport slave (
        input  ch_sel, adc_soc, res_valid, res_ch, res_data,
        output adc_eoc, adc_eoc_it, adc_dout
    );
endinterface

// File: rtl/adc_sar_seq_chpick.sv
// Priority picker: next enabled channel above cur, plus lowest enabled channel of a fresh mask.
// Latency: combinational.
// Backpressure: n/a.
module adc_sar_seq_chpick
    import adc_sar_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic [NCH-1:0] mask,
    input  logic [CW-1:0]  cur,
    input  logic [NCH-1:0] new_mask,
    output logic [CW-1:0]  nxt,
    output logic           wrap,
    output logic [CW-1:0]  first
);

    logic [15:0] mask16;
    logic [15:0] new16;
    logic [3:0]  cur4;
    logic [4:0]  r_nxt;
    logic [4:0]  r_first;
    // Index bits above CW are always zero for a legal NCH; fold them into a sink.
    logic        unused_bits;

    // Widen to the 16-channel helper and narrow the answers back to CW bits.
    always_comb begin
        mask16              = '0;
        new16               = '0;
        cur4                = '0;
        mask16[NCH-1:0]     = mask;
        new16[NCH-1:0]      = new_mask;
        cur4[CW-1:0]        = cur;
        r_nxt               = next_channel(mask16, cur4);
        r_first             = next_channel(new16, 4'hF);
        nxt                 = r_nxt[CW-1:0];
        wrap                = r_nxt[4];
        first               = r_first[CW-1:0];
    end

    assign unused_bits = ^{r_nxt, r_first};

endmodule

// File: rtl/adc_sar_sequencer.sv
// Multi-channel SAR scan controller: mux select, settle wait, soc/eoc handshake, tagged results.
// Latency: result strobe one cycle after the last adc_eoc_it of a channel; ch_sel valid the cycle after start.
// Backpressure: paced only by adc_eoc/adc_eoc_it with a TIMEOUT guard; ADC_SEQ_AVERAGING_EN adds per-channel averaging.
module adc_sar_sequencer
    import adc_sar_pkg::*;
#(
    parameter int N        = 12,
    parameter int NCH      = 4,
    parameter int SETTLE_W = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [NCH-1:0]      ch_mask,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [1:0]          avg_log2,
    output logic                busy,
    output logic                seq_done,
    output logic                err_timeout,
    adc_sar_sequencer_if.master bus
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_SETTLE = SETTLE;
    localparam logic [2:0] ST_SOC    = SOC;
    localparam logic [2:0] ST_CONV   = CONV;
    localparam logic [2:0] ST_NEXT   = NEXT;

    logic [2:0]          state;
    logic [NCH-1:0]      mask_q;
    logic [CW-1:0]       ch_q;
    logic [CW-1:0]       nxt_ch;
    logic [CW-1:0]       first_ch;
    logic                wrap;
    logic [SETTLE_W-1:0] set_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic                tmo_hit;
    logic                soc_q;
    logic                res_vld_q;
    logic [CW-1:0]       res_ch_q;
    logic [N-1:0]        res_dat_q;
    logic                done_q;
    logic                tmo_q;
    logic                stop_pend;
    logic                stop_eff;

`ifdef ADC_SEQ_AVERAGING_EN
    localparam int AW = N + ADC_SEQ_ACC_EXTRA;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_sum;
    logic [2:0]    smp_cnt;
    logic [1:0]    avg_q;
    logic          last_smp;

    assign acc_sum  = acc_q + AW'(bus.adc_dout);
    assign last_smp = (smp_cnt == 3'((4'd1 << avg_q) - 4'd1));
`else
    // Without averaging the sample-count input has no effect.
    logic unused_avg;
    assign unused_avg = ^avg_log2;
`endif

    adc_sar_seq_chpick #(
        .NCH (NCH),
        .CW  (CW)
    ) u_pick (
        .mask     (mask_q),
        .cur      (ch_q),
        .new_mask (ch_mask),
        .nxt      (nxt_ch),
        .wrap     (wrap),
        .first    (first_ch)
    );

    // A stop seen in the same cycle as NEXT counts as pending.
    assign stop_eff = stop_pend | stop;
    assign tmo_hit  = ((state == ST_SOC) || (state == ST_CONV)) &&
                      (tmo_cnt == TW'(TIMEOUT - 1));

    // Scan FSM, handshake driver, timeout guard and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            ch_q      <= '0;
            set_cnt   <= '0;
            tmo_cnt   <= '0;
            soc_q     <= 1'b0;
            res_vld_q <= 1'b0;
            res_ch_q  <= '0;
            res_dat_q <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            stop_pend <= 1'b0;
`ifdef ADC_SEQ_AVERAGING_EN
            acc_q     <= '0;
            smp_cnt   <= '0;
            avg_q     <= '0;
`endif
        end else if (!enable) begin
            // Abort: drop everything in flight, no result and no done pulse.
            state     <= ST_IDLE;
            soc_q     <= 1'b0;
            res_vld_q <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            stop_pend <= 1'b0;
            tmo_cnt   <= '0;
            set_cnt   <= '0;
        end else begin
            res_vld_q <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
            if ((state != ST_IDLE) && stop) stop_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    tmo_cnt   <= '0;
                    stop_pend <= 1'b0;
`ifdef ADC_SEQ_AVERAGING_EN
                    acc_q     <= '0;
                    smp_cnt   <= '0;
`endif
                    if (start && (ch_mask != '0)) begin
                        mask_q  <= ch_mask;
                        ch_q    <= first_ch;
                        set_cnt <= '0;
                        state   <= ST_SETTLE;
`ifdef ADC_SEQ_AVERAGING_EN
                        avg_q   <= avg_log2;
`endif
                    end
                end

                ST_SETTLE: begin
                    if (set_cnt >= settle) begin
                        state   <= ST_SOC;
                        tmo_cnt <= '0;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end

                ST_SOC: begin
                    if (tmo_hit) begin
                        soc_q     <= 1'b0;
                        tmo_q     <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (!soc_q) begin
                        if (bus.adc_eoc) soc_q <= 1'b1;
                    end else if (!bus.adc_eoc) begin
                        // The adc has taken the request; release soc and wait for the result.
                        soc_q   <= 1'b0;
                        state   <= ST_CONV;
                        tmo_cnt <= '0;
                    end
                end

                ST_CONV: begin
                    if (tmo_hit) begin
                        tmo_q     <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (bus.adc_eoc_it) begin
                        tmo_cnt <= '0;
`ifdef ADC_SEQ_AVERAGING_EN
                        if (last_smp) begin
                            res_vld_q <= 1'b1;
                            res_ch_q  <= ch_q;
                            res_dat_q <= N'(acc_sum >> avg_q);
                            acc_q     <= '0;
                            smp_cnt   <= '0;
                            state     <= ST_NEXT;
                        end else begin
                            // Back-to-back conversion on the same channel, no resettle.
                            acc_q     <= acc_sum;
                            smp_cnt   <= smp_cnt + 1'b1;
                            state     <= ST_SOC;
                        end
`else
                        res_vld_q <= 1'b1;
                        res_ch_q  <= ch_q;
                        res_dat_q <= bus.adc_dout;
                        state     <= ST_NEXT;
`endif
                    end
                end

                ST_NEXT: begin
                    tmo_cnt <= '0;
                    if (!wrap && !stop_eff) begin
                        ch_q    <= nxt_ch;
                        set_cnt <= '0;
                        state   <= ST_SETTLE;
                    end else begin
                        done_q    <= 1'b1;
                        stop_pend <= 1'b0;
                        if (wrap && continuous && !stop_eff) begin
                            // Rescan picks up whatever mask software holds now.
                            mask_q <= ch_mask;
                            if (ch_mask != '0) begin
                                ch_q    <= first_ch;
                                set_cnt <= '0;
                                state   <= ST_SETTLE;
                            end else begin
                                state   <= ST_IDLE;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = (state != ST_IDLE);
    assign seq_done       = done_q;
    assign err_timeout    = tmo_q;
    assign bus.ch_sel     = ch_q;
    assign bus.adc_soc    = soc_q;
    assign bus.res_valid  = res_vld_q;
    assign bus.res_ch     = res_ch_q;
    assign bus.res_data   = res_dat_q;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Directed bench for adc_sar_sequencer with a behavioural adc_sar model and result scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_sar_sequencer;

    localparam int N        = 12;
    localparam int NCH      = 4;
    localparam int SETTLE_W = 4;
    localparam int TIMEOUT  = 1023;

    logic                clk;
    logic                rst;
    logic                enable;
    logic                start;
    logic                stop;
    logic                continuous;
    logic [NCH-1:0]      ch_mask;
    logic [SETTLE_W-1:0] settle;
    logic [1:0]          avg_log2;
    logic                busy;
    logic                seq_done;
    logic                err_timeout;

    adc_sar_sequencer_if #(.N(N), .NCH(NCH)) bus ();

    adc_sar_sequencer #(
        .N        (N),
        .NCH      (NCH),
        .SETTLE_W (SETTLE_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .ch_mask     (ch_mask),
        .settle      (settle),
        .avg_log2    (avg_log2),
        .busy        (busy),
        .seq_done    (seq_done),
        .err_timeout (err_timeout),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // scoreboard
    int           exp_ch[$];
    logic [N-1:0] exp_dat[$];

    // monitor counters
    int n_res, n_done, n_tmo;
    int last_res_cyc, last_done_cyc;
    int sel_cyc, min_gap;
    logic [1:0] prev_ch;
    logic       prev_soc;

    // adc model state
    int  samp_n        = 0;
    int  conv_started  = 0;
    int  val_base      = 1000;
    int  val_step      = 37;
    bit  model_stuck   = 0;
    bit  active        = 0;
    int  mcnt          = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_val(input int n);
        return N'(val_base + n * val_step);
    endfunction

    task automatic clr_counts();
        n_res = 0; n_done = 0; n_tmo = 0;
        last_res_cyc = 0; last_done_cyc = 0;
        min_gap = 1000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_soc(input string tag, input int budget);
        int k = 0;
        while (bus.adc_soc !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, bus.adc_soc, 1);
    endtask

    // Behavioural adc_sar: eoc idles high, drops when soc is seen, result pulse 14 cycles later.
    initial begin
        bus.adc_eoc    = 1'b1;
        bus.adc_eoc_it = 1'b0;
        bus.adc_dout   = '0;
        forever begin
            @(negedge clk);
            bus.adc_eoc_it = 1'b0;
            if (active) begin
                mcnt++;
                if (mcnt == 14) begin
                    bus.adc_eoc_it = 1'b1;
                    bus.adc_dout   = model_val(samp_n);
                    samp_n++;
                    bus.adc_eoc    = 1'b1;
                    active         = 0;
                end
            end else if (bus.adc_soc === 1'b1 && !model_stuck && bus.adc_eoc) begin
                active       = 1;
                mcnt         = 0;
                bus.adc_eoc  = 1'b0;
                conv_started++;
            end
        end
    end

    // Output monitor: scoreboard compare on each result strobe, pulse counters, settle gap.
    initial begin
        prev_ch  = '0;
        prev_soc = 1'b0;
        sel_cyc  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.res_valid === 1'b1) begin
                    n_res++;
                    last_res_cyc = cyc;
                    check("res_has_expectation", (exp_ch.size() != 0), 1);
                    if (exp_ch.size() != 0) begin
                        check("res_ch", bus.res_ch, exp_ch.pop_front());
                        check("res_data", bus.res_data, exp_dat.pop_front());
                    end
                end
                if (seq_done === 1'b1) begin
                    n_done++;
                    last_done_cyc = cyc;
                end
                if (err_timeout === 1'b1) n_tmo++;
                if (bus.ch_sel !== prev_ch) sel_cyc = cyc;
                if (bus.adc_soc === 1'b1 && prev_soc === 1'b0 && (cyc - sel_cyc) < min_gap)
                    min_gap = cyc - sel_cyc;
            end
            prev_ch  = bus.ch_sel;
            prev_soc = bus.adc_soc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int rise;
        int k;
        rst = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        ch_mask = '0; settle = 4'd3; avg_log2 = 2'd0;
        clr_counts();
        repeat (3) @(negedge clk);

        // reset state
        check("rst_busy", busy, 0);
        check("rst_soc", bus.adc_soc, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_ch_sel", bus.ch_sel, 0);
        check("rst_res_data", bus.res_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // two-channel single scan
        clr_counts();
        exp_ch.push_back(1); exp_dat.push_back(model_val(samp_n));
        exp_ch.push_back(3); exp_dat.push_back(model_val(samp_n + 1));
        ch_mask = 4'b1010; continuous = 1'b0;
        pulse_start();
        check("t1_busy_after_start", busy, 1);
        check("t1_first_ch_sel", bus.ch_sel, 1);
        wait_idle("t1_scan_ends", 500);
        repeat (3) @(negedge clk);
        check("t1_res_count", n_res, 2);
        check("t1_done_count", n_done, 1);
        check("t1_no_timeout", n_tmo, 0);
        check("t1_queue_drained", exp_ch.size(), 0);
        check("t1_settle_gap_ge3", (min_gap >= 3), 1);
        check("t1_res_ch_held", bus.res_ch, 3);
        check("t1_res_data_held", bus.res_data, model_val(samp_n - 1));

        // continuous single channel, stop during the third conversion
        clr_counts();
        for (int i = 0; i < 3; i++) begin
            exp_ch.push_back(0); exp_dat.push_back(model_val(samp_n + i));
        end
        ch_mask = 4'b0001; continuous = 1'b1;
        c0 = conv_started;
        pulse_start();
        k = 0;
        while (conv_started != c0 + 3 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t2_third_conv_seen", conv_started, c0 + 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("t2_scan_ends", 300);
        repeat (3) @(negedge clk);
        continuous = 1'b0;
        check("t2_res_count", n_res, 3);
        check("t2_done_per_wrap", n_done, 3);
        check("t2_done_after_last_res", (last_done_cyc > last_res_cyc), 1);
        check("t2_no_fourth_conv", conv_started, c0 + 3);
        check("t2_queue_drained", exp_ch.size(), 0);

        // empty mask and disabled block ignore start
        clr_counts();
        ch_mask = 4'b0000;
        pulse_start();
        check("t3_empty_mask_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("t3_empty_mask_done", n_done, 0);
        check("t3_empty_mask_tmo", n_tmo, 0);
        enable = 1'b0; ch_mask = 4'b0001;
        pulse_start();
        check("t3_disabled_busy", busy, 0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_disabled_stays_idle", busy, 0);

        // enable drop while soc is high
        clr_counts();
        ch_mask = 4'b0100;
        pulse_start();
        wait_soc("t4_soc_rises", 200);
        enable = 1'b0;
        @(negedge clk);
        check("t4_abort_soc", bus.adc_soc, 0);
        check("t4_abort_busy", busy, 0);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_no_result", n_res, 0);
        check("t4_no_done", n_done, 0);

        // adc never acknowledges: handshake timeout
        clr_counts();
        model_stuck = 1;
        ch_mask = 4'b0001;
        pulse_start();
        wait_soc("t5_soc_rises", 200);
        rise = cyc;
        k = 0;
        while (err_timeout !== 1'b1 && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        check("t5_timeout_seen", err_timeout, 1);
        check("t5_timeout_delay", cyc - rise, TIMEOUT - 1);
        check("t5_soc_dropped", bus.adc_soc, 0);
        check("t5_idle", busy, 0);
        @(negedge clk);
        check("t5_timeout_one_cycle", err_timeout, 0);
        model_stuck = 0;
        repeat (3) @(negedge clk);
        check("t5_no_done", n_done, 0);
        check("t5_tmo_count", n_tmo, 1);

`ifdef ADC_SEQ_AVERAGING_EN
        // four-sample average on channel 2
        clr_counts();
        val_step = 1;
        val_base = 100 - samp_n;
        avg_log2 = 2'd2;
        ch_mask  = 4'b0100;
        exp_ch.push_back(2); exp_dat.push_back(N'(101));
        pulse_start();
        wait_idle("t6_scan_ends", 800);
        repeat (3) @(negedge clk);
        check("t6_single_result", n_res, 1);
        check("t6_queue_drained", exp_ch.size(), 0);
        avg_log2 = 2'd0;
        val_step = 37;
`endif

        // reset mid-scan clears the outputs
        ch_mask = 4'b0010;
        pulse_start();
        wait_soc("t7_soc_rises", 200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_soc", bus.adc_soc, 0);
        check("t7_rst_res_data", bus.res_data, 0);
        check("t7_rst_ch_sel", bus.ch_sel, 0);
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
